rv32i_multicycle_controller: RTL and testbench
==============================================

Name: rv32i_multicycle_controller

Overview:
Parametrised multicycle successor to the single-cycle RV32I decoder. A state machine sequences fetch, decode, execute, memory and writeback over one shared memory port with a req/ready handshake. It decodes the full RV32I base set (ALU R/I, LUI, AUIPC, JAL, JALR, branches, loads, stores), traps on illegal encodings or memory timeout, and counts retired instructions. It sits between the IR/PC/ALUOut datapath registers and the register file, ALU and memory.

Parameters:
ALU_CTRL_W, 4, alu_control width; must be at least 4.
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready; 0 disables the timeout.
CNT_W, 32, instret counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
instr  in  32  current IR contents (held by datapath)
alu_zero  in  1  ALU result == 0
alu_lt  in  1  ALU result[0] (slt/sltu outcome)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  store request
mem_addr_sel  out  1  0 = PC, 1 = ALUOut
ir_we  out  1  load IR from memory read data
reg_we  out  1  register file write
pc_we  out  1  PC update
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALUOut
alu_src_a  out  2  00 rs1, 01 PC, 10 zero
alu_src_b  out  1  0 rs2, 1 imm
imm_sel  out  3  000 I, 001 S, 010 B, 011 U, 100 J
wb_sel  out  2  00 ALUOut, 01 mem data, 10 PC+4
alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and (zero-extended)
trap  out  1  sticky halt indication
trap_cause  out  2  01 illegal instruction, 10 memory timeout
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (async): state=FETCH, instret=0, trap=0, trap_cause=0, timeout counter=0. All strobes (mem_req, mem_we, ir_we, reg_we, pc_we) are 0 while rst is high. Strobes are combinational from state, instr and flags. The datapath captures ALUOut every cycle.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ready: ir_we=1, go to DECODE. Otherwise stay.
- DECODE (1 cycle): legal instruction -> EXECUTE; illegal -> TRAP with cause 01.
- EXECUTE (1 cycle):
  - R-type: a=rs1, b=rs2.
  - OP-IMM: a=rs1, b=imm I.
  - LUI: a=zero, b=imm U.
  - AUIPC: a=PC, b=imm U.
  - JALR: add rs1+imm I.
  - Load/store: add rs1+imm I/S, then go to MEM.
  - Branch: beq/bne use sub with alu_zero; blt/bge use slt with alu_lt; bltu/bgeu use sltu with alu_lt. Asserts pc_we with pc_sel=01 if taken, else 00. Retires; go to FETCH.
  - JAL: no ALU use.
  - All others go to WB.
- ALU decode: funct7[5] (instr[30]) selects sub only for R-type funct3=000. For srl/sra it applies to both R-type and OP-IMM. addi/xori/slti/sltiu/ori/andi/slli/srli/srai all map to the codes above.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores. Wait for mem_ready. Store: pc_we with pc_sel=00, retire, go to FETCH. Load: go to WB.
- WB (1 cycle): reg_we=1 unless rd==0. pc_we=1. Retire; go to FETCH. Selects per instruction:
  - loads: wb_sel=01
  - JAL: wb_sel=10, pc_sel=01, imm J
  - JALR: wb_sel=10, pc_sel=10
  - all others: wb_sel=00, pc_sel=00
- Retire: instret increments by 1 on the retiring cycle and wraps modulo 2^CNT_W.
- Illegal encodings:
  - unknown opcode
  - R-type funct7 not 0000000, or 0100000 with funct3 not in {000, 101}
  - slli funct7≠0; srli/srai funct7 not in {0000000, 0100000}
  - branch funct3 010/011
  - load funct3 011/110/111
  - store funct3 >010
  - JALR funct3≠000
- Timeout: the counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0. When it reaches MEM_TIMEOUT (nonzero), go to TRAP with cause 10. A mem_ready arriving on that same cycle wins: the request completes and there is no trap.
- TRAP: all strobes 0. trap and trap_cause are held until reset; no further fetch.

Test Plan:
- Reset, then mem_ready=1 every cycle with instr=0x002081B3 (add x3,x1,x2): FETCH/DECODE/EXECUTE/WB. WB shows reg_we=1, wb_sel=00, pc_sel=00, alu_control=0. instret=1 after 4 cycles.
- instr=0x4020D193 (srai x3,x1,2): alu_control=7, alu_src_b=1. instr=0x0020D193 (srli): alu_control=6.
- instr=0x0000A183 (lw) with mem_ready low for 3 cycles in MEM: mem_req held, mem_addr_sel=1, no trap. WB wb_sel=01. 7 cycles total.
- instr=0x00208463 (beq) with alu_zero=1: in EXECUTE alu_control=1, pc_we=1, pc_sel=01, instret+1. Repeat with alu_zero=0: pc_sel=00.
- instr=0x0000007F: TRAP after DECODE, trap_cause=01, no further mem_req. mem_ready stuck low in FETCH: trap_cause=10 after 16 cycles. Assert rst mid-TRAP: trap clears and FETCH resumes.
- rd=x0 ALU instruction: reg_we=0 in WB. instret with CNT_W=4 wraps 15 -> 0.

Source files
------------

// File: rtl/rv32i_multicycle_controller.sv
// rv32i_multicycle_controller
//   Multicycle control unit for an RV32I core sharing one memory port.
//   Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB), decodes the RV32I
//   base set, traps on illegal encodings or a stalled memory, and counts
//   retired instructions.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   instr               IR contents held by the datapath
//   alu_zero, alu_lt    ALU flags (result == 0, result[0])
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_we     memory request / store request
//   mem_addr_sel        0 = PC, 1 = ALUOut
//   ir_we, reg_we       IR load, register file write
//   pc_we, pc_sel       PC update; 00 PC+4, 01 PC+imm, 10 ALUOut
//   alu_src_a/b         A: 00 rs1, 01 PC, 10 zero; B: 0 rs2, 1 imm
//   imm_sel             000 I, 001 S, 010 B, 011 U, 100 J
//   wb_sel              00 ALUOut, 01 memory data, 10 PC+4
//   alu_control         ALU operation code (zero-extended)
//   trap, trap_cause    sticky halt; 01 illegal, 10 memory timeout
//   instret             retired instruction count (wraps)
module rv32i_multicycle_controller #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_addr_sel,
  output logic                  ir_we,
  output logic                  reg_we,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic [1:0]            alu_src_a,
  output logic                  alu_src_b,
  output logic [2:0]            imm_sel,
  output logic [1:0]            wb_sel,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [CNT_W-1:0]      instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers and immediates are consumed by the datapath only.
  logic unused_fields;
  assign unused_fields = ^instr[24:15];

  // funct7[5] picks sub only on R-type add; it picks sra on both shift forms.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt,
                                       input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Instruction decode
  logic       legal, is_load, is_store, is_branch, is_jal, is_jalr, taken;
  alu_op_t    dec_alu;
  logic [1:0] dec_src_a;
  logic       dec_src_b;
  logic [2:0] dec_imm;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    legal     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    taken     = 1'b0;
    dec_alu   = ALU_ADD;
    dec_src_a = 2'b00;
    dec_src_b = 1'b0;
    dec_imm   = 3'b000;
    case (opcode)
      OP_R: begin
        legal   = (funct7 == F7_ZERO) ||
                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        dec_alu = arith_op(funct3, instr[30], 1'b1);
      end
      OP_IMM: begin
        if (funct3 == 3'b001)      legal = (funct7 == F7_ZERO);
        else if (funct3 == 3'b101) legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        else                       legal = 1'b1;
        dec_alu   = arith_op(funct3, instr[30], 1'b0);
        dec_src_b = 1'b1;
      end
      OP_LUI: begin
        legal     = 1'b1;
        dec_src_a = 2'b10;
        dec_src_b = 1'b1;
        dec_imm   = 3'b011;
      end
      OP_AUIPC: begin
        legal     = 1'b1;
        dec_src_a = 2'b01;
        dec_src_b = 1'b1;
        dec_imm   = 3'b011;
      end
      OP_JAL: begin
        legal   = 1'b1;
        is_jal  = 1'b1;
        dec_imm = 3'b100;
      end
      OP_JALR: begin
        legal     = (funct3 == 3'b000);
        is_jalr   = 1'b1;
        dec_src_b = 1'b1;
      end
      OP_BRANCH: begin
        legal     = (funct3[2:1] != 2'b01);
        is_branch = 1'b1;
        dec_imm   = 3'b010;
        dec_alu   = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        // funct3[0] inverts the sense: bne/bge/bgeu.
        taken     = (funct3[2] ? alu_lt : alu_zero) ^ funct3[0];
      end
      OP_LOAD: begin
        legal     = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        is_load   = 1'b1;
        dec_src_b = 1'b1;
      end
      OP_STORE: begin
        legal     = (funct3 <= 3'b010);
        is_store  = 1'b1;
        dec_src_b = 1'b1;
        dec_imm   = 3'b001;
      end
      default: legal = 1'b0;
    endcase
  end

  // State machine
  state_t          state, state_next;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout_hit, retire, drive_alu;
  logic            mem_req_c, mem_we_c, ir_we_c, reg_we_c, pc_we_c;
  logic [1:0]      cause_next;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

  always_comb begin
    state_next   = state;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_we_c      = 1'b0;
    reg_we_c     = 1'b0;
    pc_we_c      = 1'b0;
    mem_addr_sel = 1'b0;
    pc_sel       = 2'b00;
    wb_sel       = 2'b00;
    retire       = 1'b0;
    drive_alu    = 1'b0;
    cause_next   = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        // A completion on the timeout cycle takes priority over the trap.
        if (mem_ready) begin
          ir_we_c    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          cause_next = CAUSE_TIMEOUT;
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXECUTE;
        end else begin
          cause_next = CAUSE_ILLEGAL;
          state_next = S_TRAP;
        end
      end
      S_EXECUTE: begin
        drive_alu = 1'b1;
        if (is_branch) begin
          pc_we_c    = 1'b1;
          pc_sel     = taken ? 2'b01 : 2'b00;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        // ALUOut is recaptured every cycle, so the address computation is
        // kept on the ALU for as long as the request is outstanding.
        drive_alu    = 1'b1;
        mem_req_c    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we_c     = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we_c    = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout_hit) begin
          cause_next = CAUSE_TIMEOUT;
          state_next = S_TRAP;
        end
      end
      S_WB: begin
        drive_alu  = 1'b1;
        reg_we_c   = (rd != 5'd0);
        pc_we_c    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
        if (is_load) begin
          wb_sel = 2'b01;
        end else if (is_jal) begin
          wb_sel = 2'b10;
          pc_sel = 2'b01;
        end else if (is_jalr) begin
          wb_sel = 2'b10;
          pc_sel = 2'b10;
        end
      end
      default: state_next = S_TRAP;
    endcase
  end

  assign alu_control = drive_alu ? ALU_CTRL_W'(dec_alu) : '0;
  assign alu_src_a   = drive_alu ? dec_src_a : 2'b00;
  assign alu_src_b   = drive_alu ? dec_src_b : 1'b0;
  assign imm_sel     = drive_alu ? dec_imm   : 3'b000;

  // The reset state is FETCH, so strobes are masked while reset is held.
  assign mem_req = mem_req_c & ~rst;
  assign mem_we  = mem_we_c  & ~rst;
  assign ir_we   = ir_we_c   & ~rst;
  assign reg_we  = reg_we_c  & ~rst;
  assign pc_we   = pc_we_c   & ~rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      instret    <= '0;
    end else begin
      state <= state_next;
      if ((state_next == S_FETCH && state != S_FETCH) ||
          (state_next == S_MEM && state != S_MEM))
        wait_cnt <= '0;
      else if (mem_req_c && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (state != S_TRAP && state_next == S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= cause_next;
      end
      if (retire)
        instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Directed testbench for rv32i_multicycle_controller (CNT_W = 4 so the
// retire counter wrap is reachable in a short run).
module tb_rv32i_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero, alu_lt, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, reg_we, pc_we;
  logic [1:0]  pc_sel, alu_src_a, wb_sel, trap_cause;
  logic        alu_src_b, trap;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_control;
  logic [3:0]  instret;

  int n_checks = 0;
  int n_errors = 0;

  rv32i_multicycle_controller #(
    .ALU_CTRL_W(4), .MEM_TIMEOUT(16), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_sel(imm_sel), .wb_sel(wb_sel), .alu_control(alu_control),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = 32'h002081B3; mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {mem_req, mem_we, ir_we, reg_we, pc_we}, 5'b0);
    check("rst_instret", instret, 4'd0);
    check("rst_trap", {trap, trap_cause}, 3'b000);

    // add x3,x1,x2 with memory always ready
    rst = 1'b0; mem_ready = 1'b1; #1;
    check("add_fetch", {mem_req, ir_we, mem_addr_sel}, 3'b110);
    step();
    check("add_decode", {mem_req, ir_we, reg_we, pc_we}, 4'b0000);
    step();
    check("add_exec", {alu_control, alu_src_a, alu_src_b, reg_we, pc_we}, {4'd0, 2'b00, 1'b0, 2'b00});
    step();
    check("add_wb", {reg_we, pc_we, wb_sel, pc_sel, alu_control}, {2'b11, 2'b00, 2'b00, 4'd0});
    check("add_wb_instret", instret, 4'd0);
    step();
    check("add_instret", instret, 4'd1);
    check("add_refetch", mem_req, 1'b1);

    // srai x3,x1,2
    instr = 32'h4020D193;
    step(); step();
    check("srai_exec", {alu_control, alu_src_b, imm_sel}, {4'd7, 1'b1, 3'b000});
    step(); step();
    check("srai_instret", instret, 4'd2);

    // srli x3,x1,2
    instr = 32'h0020D193;
    step(); step();
    check("srli_exec", alu_control, 4'd6);
    step(); step();
    check("srli_instret", instret, 4'd3);

    // lw x3,0(x1) with three unanswered MEM cycles
    instr = 32'h0000A183;
    step();
    mem_ready = 1'b0;
    step();
    check("lw_exec", {alu_control, alu_src_b, imm_sel}, {4'd0, 1'b1, 3'b000});
    step();
    check("lw_mem0", {mem_req, mem_addr_sel, mem_we}, 3'b110);
    step(); step();
    check("lw_mem2", {mem_req, mem_addr_sel, trap, pc_we}, 4'b1100);
    mem_ready = 1'b1; #1;
    check("lw_mem_done", {mem_req, reg_we, pc_we}, 3'b100);
    step();
    check("lw_wb", {wb_sel, reg_we, pc_we, pc_sel}, {2'b01, 2'b11, 2'b00});
    step();
    check("lw_instret", instret, 4'd4);

    // sw x2,4(x1)
    instr = 32'h0020A223;
    step(); step();
    check("sw_exec", {imm_sel, alu_src_b, alu_control}, {3'b001, 1'b1, 4'd0});
    step();
    check("sw_mem", {mem_req, mem_we, mem_addr_sel, pc_we, pc_sel, reg_we}, {4'b1111, 2'b00, 1'b0});
    step();
    check("sw_instret", instret, 4'd5);

    // beq x1,x2 taken then not taken
    instr = 32'h00208463; alu_zero = 1'b1;
    step(); step();
    check("beq_taken", {alu_control, pc_we, pc_sel, imm_sel}, {4'd1, 1'b1, 2'b01, 3'b010});
    step();
    check("beq_taken_instret", {instret, mem_req}, {4'd6, 1'b1});
    alu_zero = 1'b0;
    step(); step();
    check("beq_not_taken", {alu_control, pc_we, pc_sel}, {4'd1, 1'b1, 2'b00});
    step();
    check("beq_nt_instret", instret, 4'd7);

    // bltu x1,x2 taken via alu_lt
    instr = 32'h0020E463; alu_lt = 1'b1;
    step(); step();
    check("bltu_exec", {alu_control, pc_we, pc_sel}, {4'd4, 1'b1, 2'b01});
    alu_lt = 1'b0;
    step();

    // add x0,x1,x2: no register write
    instr = 32'h00208033;
    step(); step(); step();
    check("x0_wb", {reg_we, pc_we}, 2'b01);
    step();
    check("x0_instret", instret, 4'd9);

    // lui x5,0x12345
    instr = 32'h123452B7;
    step(); step();
    check("lui_exec", {alu_src_a, alu_src_b, imm_sel, alu_control}, {2'b10, 1'b1, 3'b011, 4'd0});
    step(); step();

    // jal x1,8
    instr = 32'h008000EF;
    step(); step(); step();
    check("jal_wb", {wb_sel, pc_sel, imm_sel, reg_we, pc_we}, {2'b10, 2'b01, 3'b100, 2'b11});
    step();

    // jalr x1,0(x2)
    instr = 32'h000100E7;
    step(); step();
    check("jalr_exec", {alu_src_a, alu_src_b, alu_control}, {2'b00, 1'b1, 4'd0});
    step();
    check("jalr_wb", {wb_sel, pc_sel, reg_we}, {2'b10, 2'b10, 1'b1});
    step();
    check("jalr_instret", instret, 4'd12);

    // Counter wraps 15 -> 0
    instr = 32'h002081B3;
    for (int i = 1; i <= 4; i++) begin
      repeat (4) step();
      check($sformatf("wrap_instret_%0d", i), instret, 32'((12 + i) % 16));
    end

    // Illegal opcode
    instr = 32'h0000007F;
    step();
    check("ill_decode", trap, 1'b0);
    step();
    check("ill_trap", {trap, trap_cause, mem_req}, {1'b1, 2'b01, 1'b0});
    repeat (3) step();
    check("ill_held", {trap, trap_cause, mem_req, ir_we, pc_we}, {1'b1, 2'b01, 3'b000});

    // Reset in TRAP
    rst = 1'b1; #1;
    check("trap_rst", {trap, trap_cause, mem_req, instret}, {3'b000, 1'b0, 4'd0});
    rst = 1'b0; mem_ready = 1'b0; instr = 32'h002081B3; #1;
    check("trap_rst_fetch", {mem_req, trap}, 2'b10);

    // Fetch timeout after 16 unanswered cycles
    repeat (15) step();
    check("to_cycle16", {mem_req, trap}, 2'b10);
    step();
    check("to_trap", {trap, trap_cause, mem_req}, {1'b1, 2'b10, 1'b0});

    // mem_ready on the timeout cycle wins; then illegal R-type (funct7 alt, funct3 001)
    rst = 1'b1; #1; rst = 1'b0; #1;
    repeat (15) step();
    instr = 32'h402091B3; mem_ready = 1'b1; #1;
    check("to_ready_wins", {mem_req, ir_we}, 2'b11);
    step();
    check("to_no_trap", {trap, mem_req}, 2'b00);
    step();
    check("ill_r_trap", {trap, trap_cause}, {1'b1, 2'b01});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
